// File: rtl/lcd_write_sched.sv
// lcd_write_sched: HD44780 write scheduler with a two-requester lock/round-robin arbiter.
// Each accepted (rs, data) byte is driven onto the LCD bus with setup, enable-pulse
// and hold timing. The scheduler then waits out the controller execution time
// before it accepts another byte.
// Ports:
//   clk, res                        - clock, synchronous active-high reset
//   reqN_valid/rs/data/last/ready   - byte stream from requester N (0: frame gen, 1: host)
//   lcd_rs, lcd_rw, lcd_en, lcd_data - LCD bus (lcd_rw tied low)
//   busy                            - scheduler is not idle
//   owner, locked                   - requester holding a multi-byte transaction
module lcd_write_sched #(
    parameter int unsigned T_PWRUP = 1000000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_HOLD  = 4,
    parameter int unsigned T_SHORT = 2500,
    parameter int unsigned T_LONG  = 100000
) (
    input  logic       clk,
    input  logic       res,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       owner,
    output logic       locked
);

    localparam int unsigned CNT_W = 24;
    localparam logic [CNT_W-1:0] C_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] C_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] C_SHORT = CNT_W'(T_SHORT - 1);
    localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(T_LONG - 1);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_rdy0, w_rdy1;
    logic             w_hs, w_sel, w_sel_rs, w_sel_last;
    logic [7:0]       w_sel_data;
    logic             w_long;

    logic             r_lcd_en, r_lcd_rs, r_busy, r_owner, r_locked, r_rr;
    logic [7:0]       r_lcd_data;

    assign w_cnt_dec  = r_cnt - CNT_W'(1);
    assign w_cnt_zero = (r_cnt == '0);

    // Clear (0x01) and return-home (0x02/0x03) commands need the long execution wait
    assign w_long = ~r_lcd_rs & ((r_lcd_data == 8'h01) | (r_lcd_data == 8'h02) |
                                 (r_lcd_data == 8'h03));

    // Next-state, shared down-counter reload and combinational grants
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rdy0      = 1'b0;
        w_rdy1      = 1'b0;
        case (r_state)
            S_PWRUP: begin
                if (w_cnt_zero) w_state_nxt = S_IDLE;
                else            w_cnt_nxt   = w_cnt_dec;
            end
            S_IDLE: begin
                // An open transaction keeps the bus with its owner; otherwise rr breaks ties
                if (r_locked) begin
                    w_rdy0 = req0_valid & ~r_owner;
                    w_rdy1 = req1_valid & r_owner;
                end else if (req0_valid & req1_valid) begin
                    w_rdy0 = ~r_rr;
                    w_rdy1 = r_rr;
                end else begin
                    w_rdy0 = req0_valid;
                    w_rdy1 = req1_valid;
                end
                if (w_rdy0 | w_rdy1) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = C_EN;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HOLD;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_long ? C_LONG : C_SHORT;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            S_WAIT: begin
                if (w_cnt_zero) w_state_nxt = S_IDLE;
                else            w_cnt_nxt   = w_cnt_dec;
            end
            default: begin
                w_state_nxt = S_PWRUP;
                w_cnt_nxt   = C_PWRUP;
            end
        endcase
    end

    // Granted requester's byte
    assign w_hs       = w_rdy0 | w_rdy1;
    assign w_sel      = w_rdy1;
    assign w_sel_rs   = w_sel ? req1_rs   : req0_rs;
    assign w_sel_data = w_sel ? req1_data : req0_data;
    assign w_sel_last = w_sel ? req1_last : req0_last;

    // State register and interval counter
    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= S_PWRUP;
            r_cnt   <= C_PWRUP;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // LCD bus, status and arbitration registers
    always_ff @(posedge clk) begin
        if (res) begin
            r_lcd_en   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
            r_busy     <= 1'b1;
            r_owner    <= 1'b0;
            r_locked   <= 1'b0;
            r_rr       <= 1'b0;
        end else begin
            r_lcd_en <= (w_state_nxt == S_PULSE);
            r_busy   <= (w_state_nxt != S_IDLE);
            if (w_hs) begin
                r_lcd_rs   <= w_sel_rs;
                r_lcd_data <= w_sel_data;
                r_owner    <= w_sel;
                r_locked   <= ~w_sel_last;
                // Closing a transaction hands priority to the other requester
                if (w_sel_last) r_rr <= ~w_sel;
            end
        end
    end

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign lcd_rs     = r_lcd_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = r_lcd_en;
    assign lcd_data   = r_lcd_data;
    assign busy       = r_busy;
    assign owner      = r_owner;
    assign locked     = r_locked;

endmodule

// File: tb/tb_lcd_write_sched.sv
// tb_lcd_write_sched: directed bench for lcd_write_sched with shortened timing parameters.
// Accepted bytes are checked against a scoreboard of expected grants; the LCD bus,
// enable pulse window and lock status are checked every cycle against a small model.
module tb_lcd_write_sched;

    localparam int T_PWRUP = 100;
    localparam int T_SETUP = 4;
    localparam int T_EN    = 25;
    localparam int T_HOLD  = 4;
    localparam int T_SHORT = 50;
    localparam int T_LONG  = 200;
    localparam int P_SHORT = 1 + T_SETUP + T_EN + T_HOLD + T_SHORT;
    localparam int P_LONG  = 1 + T_SETUP + T_EN + T_HOLD + T_LONG;
    localparam int HS_BUDGET = 400;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_last = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_last = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic       lcd_rs, lcd_rw, lcd_en, busy, owner, locked;
    logic [7:0] lcd_data;

    lcd_write_sched #(
        .T_PWRUP (T_PWRUP),
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_HOLD  (T_HOLD),
        .T_SHORT (T_SHORT),
        .T_LONG  (T_LONG)
    ) dut (
        .clk        (clk),
        .res        (res),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data),
        .busy       (busy),
        .owner      (owner),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       n;
        logic       rs;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    int   prev_hs = 0;

    // Reference model of the bus registers
    int         m_hs = -1000000;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       m_locked = 1'b0;
    logic       m_owner = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle bus/status checks and scoreboard pop on each handshake
    always @(negedge clk) begin
        exp_t e;
        logic hn;
        if (mon_en) begin
            chk("lcd_en", lcd_en, (cyc >= m_hs + 1 + T_SETUP) && (cyc <= m_hs + T_SETUP + T_EN));
            chk("lcd_data", lcd_data, m_data);
            chk("lcd_rs", lcd_rs, m_rs);
            chk("lcd_rw", lcd_rw, 1'b0);
            chk("locked", locked, m_locked);
            if (m_locked) chk("owner", owner, m_owner);
            chk("ready_excl", req0_ready & req1_ready, 1'b0);
            if (res) begin
                m_hs     = -1000000;
                m_rs     = 1'b0;
                m_data   = 8'h00;
                m_locked = 1'b0;
                m_owner  = 1'b0;
            end else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                hn = req1_valid && req1_ready;
                chk("busy_at_hs", busy, 1'b0);
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_req", hn, e.n);
                    chk("sb_rs", hn ? req1_rs : req0_rs, e.rs);
                    chk("sb_data", hn ? req1_data : req0_data, e.d);
                end
                m_hs     = cyc;
                m_rs     = hn ? req1_rs : req0_rs;
                m_data   = hn ? req1_data : req0_data;
                m_locked = !(hn ? req1_last : req0_last);
                m_owner  = hn;
            end
        end
    end

    task automatic wait_hs(output int at, output logic n);
        bit got;
        got = 1'b0;
        at  = -1;
        n   = 1'b0;
        for (int i = 0; i < HS_BUDGET && !got; i++) begin
            @(negedge clk);
            if (!res && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
                got = 1'b1;
                at  = cyc;
                n   = req1_valid && req1_ready;
            end
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL hs_timeout observed=none expected=handshake within %0d cycles", HS_BUDGET);
        end
    endtask

    task automatic drive(input logic n, input logic rs, input logic [7:0] d, input logic last);
        if (n) begin
            req1_valid = 1'b1; req1_rs = rs; req1_data = d; req1_last = last;
        end else begin
            req0_valid = 1'b1; req0_rs = rs; req0_data = d; req0_last = last;
        end
    endtask

    task automatic send(input logic n, input logic rs, input logic [7:0] d, input logic last,
                        input int gap, input string tag, input bit drop);
        int   at;
        logic g;
        sb.push_back({n, rs, d});
        drive(n, rs, d, last);
        wait_hs(at, g);
        chk({tag, "_cycle"}, at, prev_hs + gap);
        chk({tag, "_req"}, g, n);
        prev_hs = at;
        @(posedge clk); #1;
        if (drop) begin
            if (n) req1_valid = 1'b0;
            else   req0_valid = 1'b0;
        end
    endtask

    initial begin
        int   at;
        int   rel;
        logic g;
        bit   seen;

        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_owner", owner, 1'b0);

        // Power-up: requester 0 waits the full delay
        @(posedge clk); #1;
        res = 1'b0;
        rel = cyc;
        sb.push_back({1'b0, 1'b0, 8'h38});
        drive(1'b0, 1'b0, 8'h38, 1'b1);
        wait_hs(at, g);
        chk("pwrup_cycle", at, rel + T_PWRUP);
        chk("pwrup_req", g, 1'b0);
        prev_hs = at;
        @(posedge clk); #1 req0_valid = 1'b0;

        // Short/long execution waits
        send(1'b1, 1'b1, 8'h41, 1'b1, P_SHORT, "short_req1", 1'b1);
        send(1'b0, 1'b0, 8'h01, 1'b1, P_SHORT, "clear", 1'b1);
        send(1'b0, 1'b0, 8'h00, 1'b1, P_LONG, "after_clear", 1'b1);
        send(1'b0, 1'b1, 8'h01, 1'b1, P_SHORT, "after_nop", 1'b1);
        send(1'b0, 1'b0, 8'h03, 1'b1, P_SHORT, "after_data01", 1'b1);
        send(1'b0, 1'b0, 8'h04, 1'b1, P_LONG, "after_home", 1'b1);

        // A valid dropped before any ready must not be latched
        drive(1'b1, 1'b1, 8'hEE, 1'b1);
        repeat (5) @(posedge clk);
        #1 req1_valid = 1'b0;

        // Lock: rr now favours requester 1, yet it must wait for all of requester 0's bytes
        send(1'b0, 1'b0, 8'h80, 1'b0, P_SHORT, "lock_b0", 1'b0);
        chk("lock_set", locked, 1'b1);
        chk("lock_owner", owner, 1'b0);
        drive(1'b1, 1'b1, 8'h5A, 1'b1);
        send(1'b0, 1'b1, 8'h48, 1'b0, P_SHORT, "lock_b1", 1'b0);
        send(1'b0, 1'b1, 8'h49, 1'b1, P_SHORT, "lock_b2", 1'b1);
        chk("lock_clear", locked, 1'b0);
        send(1'b1, 1'b1, 8'h5A, 1'b1, P_SHORT, "lock_req1", 1'b1);

        // Round-robin between continuously valid single-byte requesters
        sb.push_back({1'b0, 1'b1, 8'h30});
        sb.push_back({1'b1, 1'b1, 8'h60});
        sb.push_back({1'b0, 1'b1, 8'h31});
        sb.push_back({1'b1, 1'b1, 8'h61});
        drive(1'b0, 1'b1, 8'h30, 1'b1);
        drive(1'b1, 1'b1, 8'h60, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_hs(at, g);
            chk("rr_cycle", at, prev_hs + P_SHORT);
            chk("rr_order", g, i % 2);
            prev_hs = at;
            @(posedge clk); #1;
            if (i < 2) begin
                if (g) req1_data = 8'h61;
                else   req0_data = 8'h31;
            end else begin
                if (g) req1_valid = 1'b0;
                else   req0_valid = 1'b0;
            end
        end

        // Reset during the enable pulse of an open transaction
        send(1'b0, 1'b1, 8'h55, 1'b0, P_SHORT, "pre_rst", 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1) seen = 1'b1;
        end
        chk("pulse_seen", seen, 1'b1);
        @(posedge clk); #1;
        res = 1'b1;
        sb.push_back({1'b1, 1'b0, 8'h38});
        drive(1'b1, 1'b0, 8'h38, 1'b1);
        @(posedge clk); #1;
        res = 1'b0;
        rel = cyc;
        @(negedge clk);
        chk("mid_rst_en", lcd_en, 1'b0);
        chk("mid_rst_data", lcd_data, 8'h00);
        chk("mid_rst_rs", lcd_rs, 1'b0);
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_busy", busy, 1'b1);
        wait_hs(at, g);
        chk("rst_pwrup_cycle", at, rel + T_PWRUP);
        chk("rst_pwrup_req", g, 1'b1);
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (5) @(posedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_write_sched.md
Name: lcd_write_sched

Overview:
- Timing-correct write scheduler and two-requester arbiter for the HD44780 character LCD on the DE2-115.
- Accepts (rs, data) byte writes over valid/ready from two upstream sources:
  - requester 0: the screen-frame generator;
  - requester 1: a command/host source.
- Generates the lcd_en pulse with setup and hold margins, then waits the controller execution time before the next write.
- Enforces the power-up delay and locks the bus to one requester for a whole multi-byte transaction, so cursor addressing is never interleaved.

Parameters:
- T_PWRUP, 1000000: cycles after reset before the first write (20 ms at 50 MHz).
- T_SETUP, 4: cycles lcd_rs/lcd_data are stable before lcd_en rises.
- T_EN, 25: cycles lcd_en is held high.
- T_HOLD, 4: cycles lcd_rs/lcd_data are held after lcd_en falls.
- T_SHORT, 2500: execution wait for ordinary commands and data (50 us).
- T_LONG, 100000: execution wait for clear/home commands (2 ms).
- All parameters must be ≥1 and <2^24. A single shared 24-bit down-counter times every interval.

Ports:
- clk  in  1  50 MHz system clock
- res  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has a byte
- req0_rs  in  1  0 = command, 1 = data
- req0_data  in  8  byte to write
- req0_last  in  1  final byte of requester 0's transaction
- req0_ready  out  1  requester 0 byte accepted this cycle when valid is also high
- req1_valid, req1_rs, req1_data, req1_last, req1_ready: same as requester 0, for requester 1
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  tied 0 (write only)
- lcd_en  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus
- busy  out  1  high in every state except IDLE
- owner  out  1  requester currently holding the lock; valid while locked is high
- locked  out  1  a transaction is in progress

Behaviour:
- Reset, sampled on the clk edge:
  - state = PWRUP, counter = T_PWRUP-1.
  - lcd_en=0, lcd_rs=0, lcd_data=0, lcd_rw=0.
  - req0_ready=0, req1_ready=0, busy=1.
  - locked=0, owner=0, round-robin pointer rr=0.
- Reset asserted mid-operation: lcd_en is low from the following edge and the latched byte is discarded.
- PWRUP: count down; at 0 go to IDLE. Both readys stay 0 throughout.
- IDLE:
  - Readys are combinational, asserted only in IDLE.
  - If locked: only reqN_ready for N = owner may be 1, equal to reqN_valid.
  - If not locked:
    - only one requester valid → that requester is granted;
    - both valid → requester rr is granted.
  - A handshake (valid & ready) latches rs/data into lcd_rs/lcd_data and moves to SETUP with counter = T_SETUP-1.
  - On the handshake:
    - if last=0: locked=1, owner=N;
    - if last=1: locked=0 and rr = other requester.
- SETUP: lcd_en=0. At counter 0 go to PULSE with counter = T_EN-1.
- PULSE: lcd_en=1. At counter 0 go to HOLD with counter = T_HOLD-1.
- HOLD: lcd_en=0, bus still held. At counter 0 go to WAIT.
  - Long wait applies when rs=0 and data is 0x01, 0x02 or 0x03 (clear/home): counter = T_LONG-1.
  - Every other byte, including 0x00: counter = T_SHORT-1.
- WAIT: at counter 0 return to IDLE.
- lcd_rs and lcd_data hold their last value in IDLE and PWRUP; after reset they hold 0.
- Timing, with the handshake on cycle 0:
  - lcd_en is high on cycles 1+T_SETUP through T_SETUP+T_EN inclusive.
  - The earliest next handshake is cycle 1+T_SETUP+T_EN+T_HOLD+Twait.
  - With defaults: 2534 cycles for a short write, 100034 for a long one.
- Boundaries:
  - A valid withdrawn before ready is ignored; no latching.
  - The non-owner's valid is held off indefinitely while locked.
  - A single-byte transaction (last=1 on the first byte) never sets locked.

Test Plan:
- Power-up: release res at cycle 0 with req0_valid=1 → no ready for 1000000 cycles; handshake on the first IDLE cycle.
- Short write: after PWRUP, req1 writes rs=1 data=0x41 at cycle 0 → lcd_en high cycles 5–29 only; lcd_data=0x41 and lcd_rs=1 stable cycles 1–2533; next accept at cycle 2534.
- Long write: rs=0 data=0x01 → lcd_en high cycles 5–29; next accept at cycle 100034. Then rs=0 data=0x00 → short wait.
- Lock: req0 sends 3 bytes (last on the third) while req1_valid is held high → all three req0 bytes are accepted before any req1 byte; req1 is granted next; locked deasserts after the third accept.
- Round-robin: both sending single-byte transactions continuously → grants alternate 0,1,0,1 starting with 0 after reset.
- Reset mid-PULSE: assert res during lcd_en=1 → lcd_en=0, lcd_data=0, lcd_rs=0, locked=0 next cycle; state returns to PWRUP with the full delay.
